rotate_scroll_ctrl: RTL and testbench

Sequencing controller for the 4×4-bit nibble rotator. It holds a loaded 4-nibble pattern and steps the rotation amount at a programmable rate, producing a scrolling display pattern for the seven-segment/LED output stage. It provides a load handshake, start/stop control, and per-step and wrap strobes for downstream logic.

---
 rtl/rotate_pkg.sv | 16 +
 rtl/rotate_scroll_ctrl_rotator.sv | 25 ++
 rtl/rotate_scroll_ctrl.sv | 159 +++++++++++++++
 tb/tb_rotate_scroll_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared types and constants for the nibble scroll controller
// Contents: nibble_t (one 4-bit display digit), NIBBLES (digits per pattern),
//           state_t (IDLE / RUN / HOLD controller states).
package rotate_pkg;

    typedef logic [3:0] nibble_t;

    localparam int NIBBLES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/rotate_scroll_ctrl_rotator.sv
// rtl/rotate_scroll_ctrl_rotator.sv - combinational 4x4-bit nibble left rotator
// Module nibble_rotator.
// Ports:
//   pattern   in  [3:0] nibbles, pattern[3] is the most significant digit
//   shift_amt in  left-rotate amount in nibbles
//   f         out rotated pattern, f[i] = pattern[(i - shift_amt) mod 4]
module nibble_rotator
    import rotate_pkg::*;
(
    input  nibble_t [NIBBLES-1:0] pattern,
    input  logic    [1:0]         shift_amt,
    output nibble_t [NIBBLES-1:0] f
);

    logic [1:0] w_src_idx [NIBBLES];

    always_comb begin
        for (int i = 0; i < NIBBLES; i++) begin
            // 2-bit subtraction gives the mod-4 wrap for free
            w_src_idx[i] = 2'(i) - shift_amt;
            f[i]         = pattern[w_src_idx[i]];
        end
    end

endmodule

// File: rtl/rotate_scroll_ctrl.sv
// rtl/rotate_scroll_ctrl.sv - scrolling sequencer driving the nibble rotator
// Optional feature macro: ROTATE_BIDIR_EN (adds the dir port for right rotation).
// Parameters:
//   TICK_DIV   clock cycles per rotation step (>= 1)
//   DIV_W      prescaler width, derived from TICK_DIV
// Ports:
//   clk, reset                system clock, asynchronous active-high reset
//   dir                       0 = left, 1 = right (ROTATE_BIDIR_EN only)
//   load_valid/ready/data     pattern load handshake
//   start, stop               level run/freeze controls, stop dominates
//   f, shift_amt              rotated pattern and current rotation amount
//   step_pulse, wrap_pulse    registered one-cycle strobes per step / on wrap
//   busy                      high while scrolling (RUN)
module rotate_scroll_ctrl
    import rotate_pkg::*;
#(
    parameter  int TICK_DIV = 50_000_000,
    localparam int DIV_W    = $clog2(TICK_DIV + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef ROTATE_BIDIR_EN
    input  logic                  dir,
`endif
    input  logic                  load_valid,
    output logic                  load_ready,
    input  nibble_t [NIBBLES-1:0] load_data,
    input  logic                  start,
    input  logic                  stop,
    output nibble_t [NIBBLES-1:0] f,
    output logic    [1:0]         shift_amt,
    output logic                  step_pulse,
    output logic                  wrap_pulse,
    output logic                  busy
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

    state_t                r_state;
    nibble_t [NIBBLES-1:0] r_pattern;
    logic    [1:0]         r_shift_amt;
    logic    [DIV_W-1:0]   r_prescaler;
    logic                  r_step_pulse;
    logic                  r_wrap_pulse;

    state_t                w_state_next;
    logic                  w_load_ready;
    logic                  w_load_fire;
    logic                  w_step;
    logic                  w_presc_clr;
    logic                  w_presc_inc;
    logic                  w_dir_right;
    logic    [1:0]         w_shift_next;
    logic                  w_wrap;

`ifdef ROTATE_BIDIR_EN
    assign w_dir_right = dir;
`else
    assign w_dir_right = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_ready = (r_state != RUN);
        w_load_fire  = load_valid & w_load_ready;
        w_step       = 1'b0;
        w_presc_clr  = 1'b0;
        w_presc_inc  = 1'b0;

        case (r_state)
            IDLE: begin
                // A load in the same cycle as start wins; start is dropped.
                if (!w_load_fire && start && !stop) begin
                    w_state_next = RUN;
                    w_presc_clr  = 1'b1;
                end
            end
            RUN: begin
                // stop pre-empts a due step, so no pulse is produced either.
                if (stop) begin
                    w_state_next = HOLD;
                end else if (r_prescaler == PRESC_LAST) begin
                    w_step      = 1'b1;
                    w_presc_clr = 1'b1;
                end else begin
                    w_presc_inc = 1'b1;
                end
            end
            HOLD: begin
                if (w_load_fire) begin
                    w_state_next = IDLE;
                end else if (start && !stop) begin
                    w_state_next = RUN;
                    w_presc_clr  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // dir is only consulted here, so a mid-period change affects the next step.
        if (w_dir_right) begin
            w_shift_next = r_shift_amt - 2'd1;
            w_wrap       = (r_shift_amt == 2'd0);
        end else begin
            w_shift_next = r_shift_amt + 2'd1;
            w_wrap       = (r_shift_amt == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern    <= '0;
            r_shift_amt  <= 2'd0;
            r_prescaler  <= '0;
            r_step_pulse <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            if (w_load_fire) begin
                r_pattern   <= load_data;
                r_shift_amt <= 2'd0;
            end else if (w_step) begin
                r_shift_amt <= w_shift_next;
            end

            if (w_presc_clr) begin
                r_prescaler <= '0;
            end else if (w_presc_inc) begin
                r_prescaler <= r_prescaler + DIV_W'(1);
            end

            // Registered strobes line up with the cycle the new f is visible.
            r_step_pulse <= w_step;
            r_wrap_pulse <= w_step & w_wrap;
        end
    end

    nibble_rotator u_rotator (
        .pattern   (r_pattern),
        .shift_amt (r_shift_amt),
        .f         (f)
    );

    assign shift_amt  = r_shift_amt;
    assign step_pulse = r_step_pulse;
    assign wrap_pulse = r_wrap_pulse;
    assign busy       = (r_state == RUN);
    assign load_ready = w_load_ready;

endmodule

// File: tb/tb_rotate_scroll_ctrl.sv
// tb/tb_rotate_scroll_ctrl.sv - directed scoreboard bench for rotate_scroll_ctrl
module tb_rotate_scroll_ctrl;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
`ifdef ROTATE_BIDIR_EN
    logic        dir = 1'b0;
`endif
    logic        load_ready;
    logic [15:0] f;
    logic [1:0]  shift_amt;
    logic        step_pulse;
    logic        wrap_pulse;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_pulse = 0;
    logic [16:0] sb_q[$];

    always #5 clk = ~clk;

    rotate_scroll_ctrl #(.TICK_DIV(TICK)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ROTATE_BIDIR_EN
        .dir        (dir),
`endif
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .start      (start),
        .stop       (stop),
        .f          (f),
        .shift_amt  (shift_amt),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge; every step strobe pops
    // one {wrap, f} expectation and must arrive exactly TICK cycles after the
    // previous strobe or RUN entry.
    task automatic run_cycles(input int n);
        logic [16:0] exp;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (step_pulse === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_step", step_pulse, 0);
                end else begin
                    exp = sb_q.pop_front();
                    chk("step_f", f, exp[15:0]);
                    chk("step_wrap", wrap_pulse, exp[16]);
                    chk("step_period", cyc - last_pulse, TICK);
                end
                last_pulse = cyc;
            end else if (wrap_pulse !== 1'b0) begin
                chk("wrap_without_step", wrap_pulse, 0);
            end
        end
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_f", f, 16'h0000);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_step", step_pulse, 0);
        chk("rst_wrap", wrap_pulse, 0);
        run_cycles(3);
        chk("idle_busy", busy, 0);

        // Load 0x1234, then scroll a full revolution
        load_valid = 1'b1;
        load_data  = 16'h1234;
        run_cycles(1);
        load_valid = 1'b0;
        chk("load_f", f, 16'h1234);
        chk("load_shift", shift_amt, 0);
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        last_pulse = cyc;
        chk("run_busy", busy, 1);
        chk("run_load_ready", load_ready, 0);
        sb_q.push_back({1'b0, 16'h2341});
        sb_q.push_back({1'b0, 16'h3412});
        sb_q.push_back({1'b0, 16'h4123});
        sb_q.push_back({1'b1, 16'h1234});
        run_cycles(16);
        chk("rev_sb_empty", sb_q.size(), 0);

        // load_valid in RUN is not accepted
        sb_q.push_back({1'b0, 16'h2341});
        load_valid = 1'b1;
        load_data  = 16'hABCD;
        run_cycles(1);
        load_valid = 1'b0;
        chk("run_load_ignored_f", f, 16'h1234);
        chk("run_load_ready_low", load_ready, 0);
        run_cycles(3);

        // stop on the cycle a step is due
        run_cycles(3);
        stop = 1'b1;
        run_cycles(1);
        stop = 1'b0;
        chk("hold_busy", busy, 0);
        chk("hold_load_ready", load_ready, 1);
        chk("hold_shift", shift_amt, 1);
        chk("hold_f", f, 16'h2341);
        run_cycles(6);
        chk("hold_frozen_shift", shift_amt, 1);

        // Resume: full period before the next step
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        last_pulse = cyc;
        sb_q.push_back({1'b0, 16'h3412});
        run_cycles(4);
        chk("resume_sb_empty", sb_q.size(), 0);

        // Load from HOLD returns to IDLE
        stop = 1'b1;
        run_cycles(1);
        stop = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'h5678;
        run_cycles(1);
        load_valid = 1'b0;
        chk("hold_load_f", f, 16'h5678);
        chk("hold_load_shift", shift_amt, 0);
        chk("hold_load_busy", busy, 0);

        // Load and start together in IDLE: load wins
        load_valid = 1'b1;
        load_data  = 16'h9ABC;
        start      = 1'b1;
        run_cycles(1);
        load_valid = 1'b0;
        start      = 1'b0;
        chk("ldstart_f", f, 16'h9ABC);
        chk("ldstart_busy", busy, 0);
        chk("ldstart_ready", load_ready, 1);
        run_cycles(5);
        chk("ldstart_still_idle", busy, 0);

        // Asynchronous reset mid-RUN
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        last_pulse = cyc;
        sb_q.push_back({1'b0, 16'hABC9});
        run_cycles(5);
        chk("pre_rst_f", f, 16'hABC9);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_f", f, 16'h0000);
        chk("arst_shift", shift_amt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_load_ready", load_ready, 1);
        chk("arst_step", step_pulse, 0);
        @(negedge clk);
        reset = 1'b0;
        run_cycles(6);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_f", f, 16'h0000);

`ifdef ROTATE_BIDIR_EN
        // Right rotation: wrap on the first step
        dir        = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h1234;
        run_cycles(1);
        load_valid = 1'b0;
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        last_pulse = cyc;
        sb_q.push_back({1'b1, 16'h4123});
        sb_q.push_back({1'b0, 16'h3412});
        run_cycles(8);
        chk("bidir_shift", shift_amt, 2);
`endif

        chk("final_sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
